// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - register map, CTRL bit indices, FSM states and reset defaults for spi_master
package configure;

  localparam logic [31:0] spi_base_addr = 32'h0000_0000;
  localparam logic [31:0] spi_top_addr  = 32'h0000_001f;

  localparam logic [15:0] spi_div_reset_default = 16'd4;

  localparam logic [4:0] off_ctrl   = 5'h00;
  localparam logic [4:0] off_div    = 5'h04;
  localparam logic [4:0] off_txdata = 5'h08;
  localparam logic [4:0] off_rxdata = 5'h0c;
  localparam logic [4:0] off_status = 5'h10;

  localparam int ctrl_en_bit      = 0;
  localparam int ctrl_cs_hold_bit = 1;
  localparam int ctrl_ie_bit      = 2;

  typedef enum logic [1:0] {
    st_idle,
    st_lead,
    st_shift,
    st_trail
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - half-period counter; step pulses once every (div+1) cycles while running
module spi_clkgen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [15:0] div,
  output logic        step
);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;

  // The divider is captured at start so register writes only affect the next transfer.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      div_d = div;
      cnt_d = div;
    end else if (run) begin
      cnt_d = (cnt_q == 16'd0) ? div_q : cnt_q - 16'd1;
    end
  end

  assign step = run && !start && (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= 16'd0;
      cnt_q <= 16'd0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - register-mapped SPI mode-0 byte master with bus decode, FSM and shifter
// Optional transfer-done interrupt output spi_irpt is built when SPI_IRPT_EN is defined.
module spi_master
  import configure::*;
#(
  parameter logic [15:0] spi_div_reset = spi_div_reset_default
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        spi_valid,
  input  logic        spi_instr,
  input  logic [31:0] spi_addr,
  input  logic [31:0] spi_wdata,
  input  logic [3:0]  spi_wstrb,
  output logic [31:0] spi_rdata,
  output logic        spi_ready,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
`ifdef SPI_IRPT_EN
  ,
  output logic        spi_irpt
`endif
);

  spi_state_e  state_q, state_d;
  logic        en_q, en_d, hold_q, hold_d, ie_q, ie_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d, rxdata_q, rxdata_d;
  logic        rxv_q, rxv_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irpt_q, irpt_d;

  logic        wr, rd, start, step;
  logic [2:0]  sel;
  logic        unused_bus;

  assign unused_bus = ^{spi_instr, spi_addr[31:5], spi_addr[1:0], spi_wdata[31:16], spi_wstrb[3:2]};

  assign wr    = spi_valid && (spi_wstrb != 4'd0);
  assign rd    = spi_valid && (spi_wstrb == 4'd0);
  assign sel   = spi_addr[4:2];
  assign start = wr && spi_wstrb[0] && (sel == off_txdata[4:2]) && (state_q == st_idle) && en_q;

  spi_clkgen u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .run   (state_q != st_idle),
    .div   (div_q),
    .step  (step)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    hold_d   = hold_q;
    ie_d     = ie_q;
    div_d    = div_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rxdata_d = rxdata_q;
    rxv_d    = rxv_q;
    hcnt_d   = hcnt_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ready_d  = spi_valid;
    rdata_d  = 32'd0;

    if (rd) begin
      case (sel)
        off_ctrl[4:2]:   rdata_d = {29'd0, ie_q, hold_q, en_q};
        off_div[4:2]:    rdata_d = {16'd0, div_q};
        off_rxdata[4:2]: rdata_d = {24'd0, rxdata_q};
        off_status[4:2]: rdata_d = {30'd0, rxv_q, state_q != st_idle};
        default:         rdata_d = 32'd0;
      endcase
    end

    if (wr && spi_wstrb[0] && (sel == off_ctrl[4:2])) begin
      en_d   = spi_wdata[ctrl_en_bit];
      hold_d = spi_wdata[ctrl_cs_hold_bit];
`ifdef SPI_IRPT_EN
      ie_d   = spi_wdata[ctrl_ie_bit];
`endif
    end
    if (wr && (&spi_wstrb[1:0]) && (sel == off_div[4:2])) begin
      div_d = spi_wdata[15:0];
    end
    if (rd && (sel == off_rxdata[4:2])) begin
      rxv_d = 1'b0;
    end

    // sclk is high on even SHIFT half-periods: rising edges sample miso, falling edges advance mosi.
    case (state_q)
      st_idle: begin
        if (start) begin
          state_d = st_lead;
          mosi_d  = spi_wdata[7];
          tx_d    = {spi_wdata[6:0], 1'b0};
          hcnt_d  = 4'd0;
        end
      end
      st_lead: begin
        if (step) begin
          state_d = st_shift;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], spi_miso};
        end
      end
      st_shift: begin
        if (step) begin
          hcnt_d = hcnt_q + 4'd1;
          if (!hcnt_q[0]) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else if (hcnt_q == 4'd15) begin
            state_d = st_trail;
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi_miso};
          end
        end
      end
      st_trail: begin
        if (step) begin
          state_d  = st_idle;
          rxdata_d = rx_q;
          rxv_d    = 1'b1;
        end
      end
    endcase

    if ((state_q != st_idle) && !en_d) begin
      state_d  = st_idle;
      sclk_d   = 1'b0;
      rxdata_d = rxdata_q;
      rxv_d    = rxv_q;
    end

    cs_n_d = (state_d != st_idle) ? 1'b0 : ~(hold_d & en_d);
    irpt_d = ie_d & rxv_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= st_idle;
      en_q     <= 1'b0;
      hold_q   <= 1'b0;
      ie_q     <= 1'b0;
      div_q    <= spi_div_reset;
      tx_q     <= 8'd0;
      rx_q     <= 8'd0;
      rxdata_q <= 8'd0;
      rxv_q    <= 1'b0;
      hcnt_q   <= 4'd0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      irpt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      hold_q   <= hold_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      rxv_q    <= rxv_d;
      hcnt_q   <= hcnt_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irpt_q   <= irpt_d;
    end
  end

  assign spi_rdata = rdata_q;
  assign spi_ready = ready_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;
`ifdef SPI_IRPT_EN
  assign spi_irpt  = irpt_q;
`else
  logic unused_irpt;
  assign unused_irpt = irpt_q;
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master: bus reads checked by a monitor, SPI pins by edge trackers
module tb_spi_master;

  localparam logic [31:0] a_ctrl = 32'h00, a_div = 32'h04, a_tx = 32'h08;
  localparam logic [31:0] a_rx = 32'h0c, a_status = 32'h10, a_unmapped = 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_valid = 1'b0;
  logic        spi_instr = 1'b0;
  logic [31:0] spi_addr = 32'd0;
  logic [31:0] spi_wdata = 32'd0;
  logic [3:0]  spi_wstrb = 4'd0;
  logic [31:0] spi_rdata;
  logic        spi_ready, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic        loop_en = 1'b0;
  logic        miso_val = 1'b0;
`ifdef SPI_IRPT_EN
  logic        spi_irpt;
  localparam logic [31:0] ctrl_readback = 32'd5;
`else
  localparam logic [31:0] ctrl_readback = 32'd1;
`endif

  assign spi_miso = loop_en ? spi_mosi : miso_val;

  always #5 clk = ~clk;

  spi_master dut (
    .rst       (rst),
    .clk       (clk),
    .spi_valid (spi_valid),
    .spi_instr (spi_instr),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_wstrb (spi_wstrb),
    .spi_rdata (spi_rdata),
    .spi_ready (spi_ready),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_cs_n  (spi_cs_n)
`ifdef SPI_IRPT_EN
    ,
    .spi_irpt  (spi_irpt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     input bit chk, input logic [31:0] exp, input string name);
    sb_q.push_back('{name: name, exp: exp, chk: chk});
    @(posedge clk); #1;
    spi_valid = 1'b1;
    spi_addr  = addr;
    spi_wdata = data;
    spi_wstrb = strb;
    @(posedge clk); #1;
    spi_valid = 1'b0;
    spi_wstrb = 4'd0;
    check({name, "_ready"}, {31'd0, spi_ready}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(addr, data, 4'hf, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus(addr, 32'd0, 4'h0, 1'b1, exp, name);
  endtask

  always @(negedge clk) begin
    if (rst && spi_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) check(mon_e.name, spi_rdata, mon_e.exp);
      end
    end
  end

  int         rises = 0, hi_cnt = 0, last_hi = 0, cs_cnt = 0, last_cs = 0;
  logic [7:0] mosi_hist = 8'd0;
  logic       sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (spi_sclk && !sclk_prev) begin
      rises++;
      mosi_hist = {mosi_hist[6:0], spi_mosi};
    end
    if (spi_sclk) hi_cnt++;
    else if (hi_cnt > 0) begin last_hi = hi_cnt; hi_cnt = 0; end
    if (!spi_cs_n) cs_cnt++;
    else if (cs_cnt > 0) begin last_cs = cs_cnt; cs_cnt = 0; end
    sclk_prev = spi_sclk;
  end

  task automatic check_reset_pins(input string tag);
    check({tag, "_ready"}, {31'd0, spi_ready}, 32'd0);
    check({tag, "_rdata"}, spi_rdata, 32'd0);
    check({tag, "_sclk"}, {31'd0, spi_sclk}, 32'd0);
    check({tag, "_mosi"}, {31'd0, spi_mosi}, 32'd0);
    check({tag, "_cs_n"}, {31'd0, spi_cs_n}, 32'd1);
`ifdef SPI_IRPT_EN
    check({tag, "_irpt"}, {31'd0, spi_irpt}, 32'd0);
`endif
  endtask

  initial begin
    int r0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("rst");
    rst = 1'b1;

    rd(a_ctrl, 32'd0, "ctrl_reset");
    rd(a_div, 32'd4, "div_reset");
    rd(a_status, 32'd0, "status_reset");
    rd(a_rx, 32'd0, "rx_reset");
    bus(a_div, 32'h7, 4'b0001, 1'b0, 32'd0, "wr_div_low_only");
    rd(a_div, 32'd4, "div_strobe_ignored");
    wr(a_rx, 32'h77);
    rd(a_rx, 32'd0, "rx_read_only");
    wr(a_tx, 32'h12);
    rd(a_tx, 32'd0, "tx_write_only");
    rd(a_status, 32'd0, "tx_dropped_en0");

    // Loopback byte at DIV=0
    wr(a_ctrl, 32'd1);
    wr(a_div, 32'd0);
    loop_en = 1'b1;
    r0 = rises;
    wr(a_tx, 32'ha5);
    rd(a_status, 32'd1, "t1_busy");
    repeat (30) @(posedge clk);
    check("t1_cs_len", last_cs, 32'd18);
    check("t1_pulses", rises - r0, 32'd8);
    check("t1_mosi", {24'd0, mosi_hist}, 32'ha5);
    rd(a_status, 32'd2, "t1_rxv");
    rd(a_rx, 32'ha5, "t1_rx");
    rd(a_status, 32'd0, "t1_rxv_clr");

    // DIV=3 with miso held high
    wr(a_div, 32'd3);
    rd(a_div, 32'd3, "div_rw");
    loop_en  = 1'b0;
    miso_val = 1'b1;
    r0 = rises;
    wr(a_tx, 32'h3c);
    repeat (90) @(posedge clk);
    check("t2_cs_len", last_cs, 32'd72);
    check("t2_half_period", last_hi, 32'd4);
    check("t2_pulses", rises - r0, 32'd8);
    check("t2_mosi", {24'd0, mosi_hist}, 32'h3c);
    rd(a_rx, 32'hff, "t2_rx");

    // Second TXDATA write while busy is dropped
    wr(a_div, 32'd0);
    loop_en = 1'b1;
    r0 = rises;
    wr(a_tx, 32'h5a);
    wr(a_tx, 32'h11);
    repeat (30) @(posedge clk);
    check("t3_cs_len", last_cs, 32'd18);
    check("t3_pulses", rises - r0, 32'd8);
    check("t3_mosi", {24'd0, mosi_hist}, 32'h5a);
    rd(a_status, 32'd2, "t3_rxv");
    rd(a_rx, 32'h5a, "t3_rx");
    rd(a_status, 32'd0, "t3_rxv_clr");

    // Abort by clearing EN mid-shift
    wr(a_tx, 32'h96);
    repeat (4) @(posedge clk);
    wr(a_ctrl, 32'd0);
    check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    rd(a_status, 32'd0, "abort_status");
    rd(a_rx, 32'h5a, "abort_rx_kept");
    repeat (25) @(posedge clk);
    rd(a_status, 32'd0, "abort_no_rxv");

    // RXDATA read lands on the completion cycle
    wr(a_ctrl, 32'd5);
    rd(a_ctrl, ctrl_readback, "ctrl_ie");
    wr(a_tx, 32'hc3);
    repeat (16) @(posedge clk);
    rd(a_rx, 32'h5a, "coinc_rx_old");
    rd(a_status, 32'd2, "coinc_rxv_kept");
`ifdef SPI_IRPT_EN
    check("irpt_set", {31'd0, spi_irpt}, 32'd1);
`endif
    rd(a_rx, 32'hc3, "coinc_rx_new");
    rd(a_status, 32'd0, "coinc_rxv_clr");
`ifdef SPI_IRPT_EN
    check("irpt_clr", {31'd0, spi_irpt}, 32'd0);
`endif

    // Reset in the middle of a DIV=3 shift
    wr(a_div, 32'd3);
    wr(a_tx, 32'hff);
    repeat (20) @(posedge clk);
    #1;
    check("mid_reset_busy_cs", {31'd0, spi_cs_n}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_pins("mid_rst");
    rst = 1'b1;
    rd(a_unmapped, 32'd0, "unmapped");
    rd(a_rx, 32'd0, "mid_rst_rx");
    rd(a_status, 32'd0, "mid_rst_status");
    rd(a_div, 32'd4, "mid_rst_div");
    rd(a_ctrl, 32'd0, "mid_rst_ctrl");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
